sum_series_framer: RTL and testbench
====================================

// Module: sum_series_framer
// PURPOSE
//   Upstream stage of the Sum accumulator. Collects a series of cfg_len input samples over a
//   valid/ready handshake into a local buffer, then replays the whole series back-to-back,
//   one word per cycle, with data_first/data_last framing.
//   Sum has no stall input and adds data_in on every cycle while busy, so a series must reach
//   it without gaps. This block guarantees that.
// PARAMETERS
//   NOF_BITS  32                      sample width; must match Sum NOF_BITS
//   MAX_LEN   16                      max series length = buffer depth (>=2)
//   LEN_W     $clog2(MAX_LEN+1)       width of cfg_len
// PORTS
//   clk        in   1         single clock, rising edge
//   rst        in   1         asynchronous, active-high reset
//   cfg_len    in   LEN_W     series length; sampled only on first accepted sample of a series
//   in_valid   in   1         upstream sample valid
//   in_data    in   NOF_BITS  upstream sample
//   in_ready   out  1         block accepts sample this cycle
//   out_data   out  NOF_BITS  -> Sum data_in
//   out_first  out  1         -> Sum data_first
//   out_last   out  1         -> Sum data_last
//   out_valid  out  1         high on every burst word (monitor only; Sum does not use it)
//   busy       out  1         high in FILL or BURST
//   cfg_err    out  1         1-cycle pulse: cfg_len was 0 or >MAX_LEN when sampled
// BEHAVIOUR
//   Reset: state=IDLE, ptrs/count=0, in_ready=0 while rst high, 1 in the first cycle after.
//     out_data=0, out_first=out_last=out_valid=busy=cfg_err=0.
//   Transfer: occurs when in_valid && in_ready at a clk edge. in_ready is combinational from
//     state only, never from in_valid.
//   Outputs out_* are registered. out_data=0 whenever out_valid=0.
//   Length: len_q = (cfg_len==0) ? 1 : (cfg_len>MAX_LEN) ? MAX_LEN : cfg_len.
//     cfg_err pulses 1 cycle after the sampling edge when clamping occurred.
//   FSM:
//     IDLE : in_ready=1. On transfer: write buf[0], latch len_q, wr_cnt=1.
//            If len_q==1 -> BURST, else -> FILL.
//     FILL : in_ready=1. Each transfer writes buf[wr_cnt], wr_cnt++.
//            The transfer that makes wr_cnt==len_q goes -> BURST. No in_valid: hold, no timeout.
//     BURST: in_ready=0. Each cycle emit buf[rd_ptr] with out_valid=1.
//              out_first = (rd_ptr==0); out_last = (rd_ptr==len_q-1).
//              Both are high together when len_q==1.
//            After emitting last -> IDLE, rd_ptr=0.
//   Latency: the last sample is accepted at edge T. out_first is visible after edge T+1.
//     The burst occupies exactly len_q consecutive cycles, never gapped.
//   Turnaround: in_ready goes high the cycle after out_last. Minimum series period = 2*len_q+0.
//     Next out_first can follow previous out_last by >=len_q+1 cycles. This is legal for Sum:
//     it is idle after done.
//   cfg_len changes during FILL/BURST are ignored.
//   Reset mid-FILL/BURST: partial series discarded, outputs zero immediately (async).
//     Top level drives Sum rst_n = ~rst, so both reset together.
// TESTING
//   1. Reset, cfg_len=4, send 1,2,3,4 with in_valid continuous -> in_ready low 4 cycles;
//      out_data 1,2,3,4 on consecutive cycles, first on 1, last on 4. Sum data_out=10, done 1 pulse.
//   2. cfg_len=1, send 0xFFFF_FFFF -> single word with out_first=out_last=1; Sum data_out=0x0_FFFF_FFFF.
//   3. cfg_len=3 with in_valid gaps (1,idle,idle,2,idle,3) -> burst still gapless 1,2,3, first-to-last 3 cycles.
//   4. cfg_len=0 -> cfg_err pulse, behaves as len 1. cfg_len=20 (MAX_LEN=16) -> cfg_err, 16-word burst.
//   5. Assert rst during BURST at word 2 of 4 -> out_* and busy drop 0 same cycle. After release,
//      new series of 2 (5,6) -> Sum data_out=11.
//   6. Change cfg_len from 4 to 2 mid-FILL -> series length stays 4. Two series back-to-back
//      (4 then 2) -> Sum done twice, outputs correct.

Source files
------------

// File: rtl/sum_series_framer.sv
// Buffers a series of cfg_len samples, then replays it as one gapless framed burst
// so the downstream Sum accumulator, which cannot stall, receives the whole series.
module sum_series_framer #(
  parameter int NOF_BITS = 32,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                in_valid,
  input  logic [NOF_BITS-1:0] in_data,
  output logic                in_ready,
  output logic [NOF_BITS-1:0] out_data,
  output logic                out_first,
  output logic                out_last,
  output logic                out_valid,
  output logic                busy,
  output logic                cfg_err
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, BURST} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]    len_clamped;
  logic                cfg_bad;
  logic                xfer;
  logic                wr_en;
  logic                emit;
  logic                err_d;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       rd_idx;
  logic [NOF_BITS-1:0] series_buf [0:MAX_LEN-1];

  always_comb begin
    cfg_bad     = (cfg_len == '0) || (cfg_len > MAX_LEN_L);
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = ONE;
    end else if (cfg_len > MAX_LEN_L) begin
      len_clamped = MAX_LEN_L;
    end
  end

  // Reset also closes the input so nothing is accepted while rst is held
  assign in_ready = !rst && (state_q != BURST);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign rd_idx   = rd_ptr_q[AW-1:0];

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    wr_idx   = wr_cnt_q[AW-1:0];
    emit     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          wr_en    = 1'b1;
          wr_idx   = '0;
          len_d    = len_clamped;
          wr_cnt_d = ONE;
          rd_ptr_d = '0;
          err_d    = cfg_bad;
          state_d  = (len_clamped == ONE) ? BURST : FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + ONE;
          if (wr_cnt_q + ONE == len_q) begin
            state_d = BURST;
          end
        end
      end
      BURST: begin
        emit = 1'b1;
        if (rd_ptr_q == len_q - ONE) begin
          rd_ptr_d = '0;
          state_d  = IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Sample storage carries no reset; contents are only read after being written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      series_buf[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      out_valid <= emit;
      out_data  <= emit ? series_buf[rd_idx] : '0;
      out_first <= emit && (rd_ptr_q == '0);
      out_last  <= emit && (rd_ptr_q == len_q - ONE);
      cfg_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_sum_series_framer.sv
// Scoreboard bench for sum_series_framer: expected burst words and series sums are queued
// as samples are driven and matched against the framed output by a monitor process.
module tb_sum_series_framer;

  localparam int NOF_BITS = 32;
  localparam int MAX_LEN  = 16;
  localparam int LEN_W    = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [NOF_BITS-1:0] data;
    logic                first;
    logic                last;
  } word_t;

  logic                clk;
  logic                rst;
  logic [LEN_W-1:0]    cfg_len;
  logic                in_valid;
  logic [NOF_BITS-1:0] in_data;
  logic                in_ready;
  logic [NOF_BITS-1:0] out_data;
  logic                out_first;
  logic                out_last;
  logic                out_valid;
  logic                busy;
  logic                cfg_err;

  int          checks;
  int          failures;
  int          series_done;
  word_t       exp_q[$];
  logic [63:0] sum_q[$];

  sum_series_framer #(
    .NOF_BITS(NOF_BITS),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_len  (cfg_len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_first(out_first),
    .out_last (out_last),
    .out_valid(out_valid),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Queue the expected burst for a series of n samples together with its Sum result
  task automatic push_series(input logic [NOF_BITS-1:0] vals[], input int n);
    logic [63:0] s;
    word_t w;
    s = '0;
    for (int i = 0; i < n; i++) begin
      w.data  = vals[i];
      w.first = (i == 0);
      w.last  = (i == n - 1);
      exp_q.push_back(w);
      s = s + {32'b0, vals[i]};
    end
    sum_q.push_back(s);
  endtask

  task automatic send(input logic [NOF_BITS-1:0] d);
    int waitc;
    waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("[TB] FAIL send_timeout: in_ready=%0b required=1 for data 0x%08h", in_ready, d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int waitc;
    waitc = 0;
    while ((exp_q.size() != 0 || out_valid) && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain: pending words=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic run_monitor();
    logic        in_burst;
    logic [63:0] acc;
    logic [63:0] exp_sum;
    word_t       e;
    in_burst = 1'b0;
    acc      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_burst = 1'b0;
      end else if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_word: out_data=0x%08h required=no word", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data) begin
            failures++;
            $display("[TB] FAIL word_data: out_data=0x%08h required=0x%08h", out_data, e.data);
          end
          checks++;
          if (out_first !== e.first || out_last !== e.last) begin
            failures++;
            $display("[TB] FAIL word_framing: first/last=%0b/%0b required=%0b/%0b",
                     out_first, out_last, e.first, e.last);
          end
        end
        acc = out_first ? {32'b0, out_data} : acc + {32'b0, out_data};
        if (out_first) in_burst = 1'b1;
        if (out_last) begin
          in_burst = 1'b0;
          series_done++;
          checks++;
          exp_sum = (sum_q.size() != 0) ? sum_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
          if (acc !== exp_sum) begin
            failures++;
            $display("[TB] FAIL series_sum: sum=0x%0h required=0x%0h", acc, exp_sum);
          end
        end
      end else begin
        checks++;
        if (in_burst || out_data !== '0 || out_first !== 1'b0 || out_last !== 1'b0) begin
          failures++;
          $display("[TB] FAIL idle_output: gap=%0b data=0x%08h first=%0b last=%0b required=0/0/0/0",
                   in_burst, out_data, out_first, out_last);
          in_burst = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: ready=%0b valid=%0b data=0x%08h busy=%0b err=%0b required all 0",
               in_ready, out_valid, out_data, busy, cfg_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready: in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [NOF_BITS-1:0] v[];
    int low_cnt, first_k;
    logic last_seen;
    v = new[4];
    v = '{32'd1, 32'd2, 32'd3, 32'd4};
    cfg_len = 4;
    push_series(v, 4);
    send(v[0]);
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_cfg_err: cfg_err=%0b required=0", cfg_err);
    end
    for (int i = 1; i < 4; i++) send(v[i]);
    low_cnt   = 0;
    first_k   = 0;
    last_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_first && first_k == 0) first_k = k;
      if (in_ready) begin
        last_seen = out_last;
        break;
      end
      low_cnt++;
    end
    checks++;
    if (low_cnt != 4) begin
      failures++;
      $display("[TB] FAIL basic_ready_low: cycles=%0d required=4", low_cnt);
    end
    checks++;
    if (first_k != 2) begin
      failures++;
      $display("[TB] FAIL basic_first_latency: cycle=%0d required=2", first_k);
    end
    checks++;
    if (last_seen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_turnaround: out_last=%0b required=1 when in_ready returns", last_seen);
    end
    wait_drain("basic");
  endtask

  task automatic test_single();
    logic [NOF_BITS-1:0] v[];
    v = new[1];
    v[0] = 32'hFFFF_FFFF;
    cfg_len = 1;
    push_series(v, 1);
    send(v[0]);
    wait_drain("single");
  endtask

  task automatic test_gaps();
    logic [NOF_BITS-1:0] v[];
    int first_k, last_k;
    v = new[3];
    v = '{32'd1, 32'd2, 32'd3};
    cfg_len = 3;
    push_series(v, 3);
    send(v[0]);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL gaps_fill_hold: busy=%0b ready=%0b required=1/1", busy, in_ready);
    end
    send(v[1]);
    @(negedge clk);
    send(v[2]);
    first_k = -1;
    last_k  = -1;
    for (int k = 1; k <= 20 && last_k < 0; k++) begin
      @(negedge clk);
      if (out_first && first_k < 0) first_k = k;
      if (out_last) last_k = k;
    end
    checks++;
    if (first_k < 0 || last_k - first_k != 2) begin
      failures++;
      $display("[TB] FAIL gaps_span: first=%0d last=%0d required span 2", first_k, last_k);
    end
    wait_drain("gaps");
  endtask

  task automatic test_clamp();
    logic [NOF_BITS-1:0] v[];
    v = new[1];
    v[0] = 32'd7;
    cfg_len = 0;
    push_series(v, 1);
    send(v[0]);
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clamp_zero_err: cfg_err=%0b required=1", cfg_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clamp_err_pulse: cfg_err=%0b required=0", cfg_err);
    end
    wait_drain("clamp_zero");
    v = new[MAX_LEN];
    for (int i = 0; i < MAX_LEN; i++) v[i] = 32'd100 + i;
    cfg_len = 20;
    push_series(v, MAX_LEN);
    send(v[0]);
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clamp_big_err: cfg_err=%0b required=1", cfg_err);
    end
    send(v[1]);
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clamp_big_pulse: cfg_err=%0b required=0", cfg_err);
    end
    for (int i = 2; i < MAX_LEN; i++) send(v[i]);
    wait_drain("clamp_big");
  endtask

  task automatic test_reset_mid_burst();
    logic [NOF_BITS-1:0] v[];
    v = new[4];
    v = '{32'd10, 32'd20, 32'd30, 32'd40};
    cfg_len = 4;
    push_series(v, 4);
    for (int i = 0; i < 4; i++) send(v[i]);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd20) begin
      failures++;
      $display("[TB] FAIL midrst_word2: valid=%0b data=0x%08h required=1/0x00000014", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_first !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_async_clear: valid=%0b data=0x%08h busy=%0b ready=%0b required all 0",
               out_valid, out_data, busy, in_ready);
    end
    exp_q.delete();
    sum_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = new[2];
    v = '{32'd5, 32'd6};
    cfg_len = 2;
    push_series(v, 2);
    send(v[0]);
    send(v[1]);
    wait_drain("midrst");
  endtask

  task automatic test_back_to_back();
    logic [NOF_BITS-1:0] a[];
    logic [NOF_BITS-1:0] b[];
    int done_before;
    a = new[4];
    a = '{32'd11, 32'd12, 32'd13, 32'd14};
    b = new[2];
    b = '{32'd7, 32'd8};
    done_before = series_done;
    cfg_len = 4;
    push_series(a, 4);
    push_series(b, 2);
    send(a[0]);
    send(a[1]);
    cfg_len = 2;
    send(a[2]);
    send(a[3]);
    send(b[0]);
    send(b[1]);
    wait_drain("b2b");
    checks++;
    if (series_done - done_before != 2) begin
      failures++;
      $display("[TB] FAIL b2b_done_count: done=%0d required=2", series_done - done_before);
    end
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    cfg_len     = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    checks      = 0;
    failures    = 0;
    series_done = 0;
    fork
      run_monitor();
      begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none
    test_reset();
    test_basic();
    test_single();
    test_gaps();
    test_clamp();
    test_reset_mid_burst();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || sum_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL final_scoreboard: words=%0d sums=%0d required=0/0", exp_q.size(), sum_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
